// File: rtl/control_cabina.sv
// Elevator car controller: latches floor calls, chooses travel direction,
// stops at requested floors and times the door with obstruction reload.
module control_cabina #(
  parameter int N_PISOS  = 10,
  parameter int T_PUERTA = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PISOS-1:0] boton,
  input  logic               sensor_piso,
  input  logic               obstaculo,
  output logic [1:0]         motor,
  output logic               puerta_abierta,
  output logic [3:0]         piso_actual,
  output logic [N_PISOS-1:0] solicitudes,
  output logic               subiendo
);

  localparam int TW = (T_PUERTA > 1) ? $clog2(T_PUERTA) : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(T_PUERTA - 1);
  localparam logic [3:0] P_MAX = 4'(N_PISOS - 1);

  localparam logic [1:0] M_STOP = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DOWN = 2'b10;

  typedef enum logic [1:0] {
    REPOSO,
    SUBE,
    BAJA,
    PUERTA
  } estado_t;

  estado_t st;
  logic [TW-1:0] tmr;

  logic [N_PISOS-1:0] req;
  logic [N_PISOS-1:0] one;
  logic [N_PISOS-1:0] msk_cur;
  logic [N_PISOS-1:0] msk_up;
  logic [N_PISOS-1:0] msk_dn;
  logic [3:0] piso_up;
  logic [3:0] piso_dn;
  logic above;
  logic below;
  logic here;

  assign req = solicitudes | boton;
  assign one = (N_PISOS)'(1);
  assign piso_up = (piso_actual >= P_MAX) ? piso_actual
                                          : piso_actual + 4'd1;
  assign piso_dn = (piso_actual == 4'd0) ? piso_actual
                                         : piso_actual - 4'd1;
  assign msk_cur = one << piso_actual;
  assign msk_up = one << piso_up;
  assign msk_dn = one << piso_dn;
  assign here = |(req & msk_cur);

  // Direction decisions look only at latched requests.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < N_PISOS; i++) begin
      if (i > int'(piso_actual)) above = above | solicitudes[i];
      if (i < int'(piso_actual)) below = below | solicitudes[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= REPOSO;
      piso_actual <= 4'd0;
      solicitudes <= '0;
      subiendo <= 1'b1;
      motor <= M_STOP;
      puerta_abierta <= 1'b0;
      tmr <= '0;
    end else begin
      solicitudes <= req;
      case (st)
        REPOSO: begin
          if (here) begin
            st <= PUERTA;
            puerta_abierta <= 1'b1;
            motor <= M_STOP;
            tmr <= T_LOAD;
            solicitudes <= req & ~msk_cur;
          end else if (above && (subiendo || !below)) begin
            st <= SUBE;
            motor <= M_UP;
            subiendo <= 1'b1;
          end else if (below) begin
            st <= BAJA;
            motor <= M_DOWN;
            subiendo <= 1'b0;
          end
        end
        SUBE: begin
          if (sensor_piso) begin
            piso_actual <= piso_up;
            if (|(req & msk_up)) begin
              st <= PUERTA;
              motor <= M_STOP;
              puerta_abierta <= 1'b1;
              tmr <= T_LOAD;
              solicitudes <= req & ~msk_up;
            end
          end
        end
        BAJA: begin
          if (sensor_piso) begin
            piso_actual <= piso_dn;
            if (|(req & msk_dn)) begin
              st <= PUERTA;
              motor <= M_STOP;
              puerta_abierta <= 1'b1;
              tmr <= T_LOAD;
              solicitudes <= req & ~msk_dn;
            end
          end
        end
        PUERTA: begin
          solicitudes <= req & ~msk_cur;
          if (obstaculo || |(boton & msk_cur)) begin
            tmr <= T_LOAD;
          end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else begin
            puerta_abierta <= 1'b0;
            if (subiendo && above) begin
              st <= SUBE;
              motor <= M_UP;
            end else if (!subiendo && below) begin
              st <= BAJA;
              motor <= M_DOWN;
            end else if (above) begin
              st <= SUBE;
              motor <= M_UP;
              subiendo <= 1'b1;
            end else if (below) begin
              st <= BAJA;
              motor <= M_DOWN;
              subiendo <= 1'b0;
            end else begin
              st <= REPOSO;
              motor <= M_STOP;
            end
          end
        end
        default: begin
          st <= REPOSO;
          motor <= M_STOP;
          puerta_abierta <= 1'b0;
          tmr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_cabina.sv
// Randomized and directed checks of control_cabina against a
// behavioural car model.
module tb_control_cabina;

  localparam int N = 10;
  localparam int T = 4;
  localparam int IDLE = 0;
  localparam int UP = 1;
  localparam int DN = 2;
  localparam int DOOR = 3;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] boton;
  logic sensor_piso;
  logic obstaculo;
  logic [1:0] motor;
  logic puerta_abierta;
  logic [3:0] piso_actual;
  logic [N-1:0] solicitudes;
  logic subiendo;

  control_cabina #(.N_PISOS(N), .T_PUERTA(T)) dut (
    .clk(clk),
    .rst(rst),
    .boton(boton),
    .sensor_piso(sensor_piso),
    .obstaculo(obstaculo),
    .motor(motor),
    .puerta_abierta(puerta_abierta),
    .piso_actual(piso_actual),
    .solicitudes(solicitudes),
    .subiendo(subiendo)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  int m_mode;
  int m_floor;
  int m_up;
  int m_left;
  bit m_pend[N];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_mode = IDLE;
    m_floor = 0;
    m_up = 1;
    m_left = 0;
    for (int i = 0; i < N; i++) m_pend[i] = 0;
  endtask

  task automatic m_step(input logic [N-1:0] b, input logic s,
                        input logic o);
    bit ab;
    bit be;
    int f;
    ab = 0;
    be = 0;
    for (int i = 0; i < N; i++) begin
      if (m_pend[i] && i > m_floor) ab = 1;
      if (m_pend[i] && i < m_floor) be = 1;
    end
    case (m_mode)
      IDLE: begin
        if (m_pend[m_floor] || b[m_floor]) begin
          m_mode = DOOR;
          m_left = T;
        end else if (ab && (m_up == 1 || !be)) begin
          m_mode = UP;
          m_up = 1;
        end else if (be) begin
          m_mode = DN;
          m_up = 0;
        end
      end
      UP, DN: begin
        if (s) begin
          f = (m_mode == UP) ? m_floor + 1 : m_floor - 1;
          if (f > N - 1) f = N - 1;
          if (f < 0) f = 0;
          m_floor = f;
          if (m_pend[f] || b[f]) begin
            m_mode = DOOR;
            m_left = T;
          end
        end
      end
      default: begin
        if (o || b[m_floor]) begin
          m_left = T;
        end else begin
          m_left--;
          if (m_left == 0) begin
            if (m_up == 1 && ab) m_mode = UP;
            else if (m_up == 0 && be) m_mode = DN;
            else if (ab) begin
              m_mode = UP;
              m_up = 1;
            end else if (be) begin
              m_mode = DN;
              m_up = 0;
            end else m_mode = IDLE;
          end
        end
      end
    endcase
    for (int i = 0; i < N; i++) m_pend[i] = m_pend[i] | b[i];
    if (m_mode == DOOR) m_pend[m_floor] = 0;
  endtask

  task automatic check_all();
    logic [N-1:0] pv;
    for (int i = 0; i < N; i++) pv[i] = m_pend[i];
    chk("motor", motor,
        (m_mode == UP) ? 1 : (m_mode == DN) ? 2 : 0);
    chk("puerta", puerta_abierta, (m_mode == DOOR) ? 1 : 0);
    chk("piso", piso_actual, m_floor);
    chk("solic", solicitudes, pv);
    chk("subiendo", subiendo, m_up);
  endtask

  task automatic cyc(input logic [N-1:0] b, input logic s,
                     input logic o);
    boton = b;
    sensor_piso = s;
    obstaculo = o;
    @(posedge clk);
    m_step(b, s, o);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    boton = '0;
    sensor_piso = 1'b0;
    obstaculo = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  int opened;
  logic [N-1:0] rb;

  initial begin
    rst = 1'b1;
    boton = '0;
    sensor_piso = 1'b0;
    obstaculo = 1'b0;
    #1;
    chk("rst_motor", motor, 0);
    do_reset();

    // call to floor 3 from floor 0
    cyc(N'(8), 1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      repeat (4) cyc('0, 1'b0, 1'b0);
      cyc('0, 1'b1, 1'b0);
    end
    chk("r27_piso", piso_actual, 3);
    opened = 0;
    for (int k = 0; k < 8; k++) begin
      if (puerta_abierta) opened++;
      cyc('0, 1'b0, 1'b0);
    end
    chk("r27_open", opened, T);
    chk("r27_solic", solicitudes, 0);
    chk("r27_motor", motor, 0);

    // door at floor 4 held by obstruction
    do_reset();
    cyc(N'(1 << 4), 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    for (int p = 0; p < 4; p++) begin
      cyc('0, 1'b0, 1'b0);
      cyc('0, 1'b1, 1'b0);
    end
    chk("r29_door", puerta_abierta, 1);
    opened = 1;
    repeat (6) begin
      cyc('0, 1'b0, 1'b1);
      if (puerta_abierta) opened++;
    end
    for (int k = 0; k < 6; k++) begin
      cyc('0, 1'b0, 1'b0);
      if (puerta_abierta) opened++;
    end
    chk("r29_open", opened, 10);

    // floor 4 button while door open restarts the count
    do_reset();
    cyc(N'(1 << 4), 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    for (int p = 0; p < 4; p++) begin
      cyc('0, 1'b0, 1'b0);
      cyc('0, 1'b1, 1'b0);
    end
    cyc('0, 1'b0, 1'b0);
    cyc(N'(1 << 4), 1'b0, 1'b0);
    chk("r29_bit4", solicitudes[4], 0);
    opened = 0;
    for (int k = 0; k < 6; k++) begin
      cyc('0, 1'b0, 1'b0);
      if (puerta_abierta) opened++;
    end
    chk("r29_restart", opened, T - 1);

    // floor 0 call plus floor 9 call while idle
    do_reset();
    cyc(N'((1 << 9) | 1), 1'b0, 1'b0);
    chk("r30_door", puerta_abierta, 1);
    chk("r30_motor", motor, 0);
    repeat (T) cyc('0, 1'b0, 1'b0);
    chk("r30_up", motor, 1);

    // reset while moving down
    do_reset();
    cyc(N'(1 << 6), 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    for (int p = 0; p < 6; p++) begin
      cyc('0, 1'b0, 1'b0);
      cyc('0, 1'b1, 1'b0);
    end
    cyc(N'(1 << 2), 1'b0, 1'b0);
    repeat (T) cyc('0, 1'b0, 1'b0);
    cyc('0, 1'b1, 1'b0);
    chk("r31_down", motor, 2);
    #3;
    rst = 1'b1;
    #1;
    chk("r31_motor", motor, 0);
    chk("r31_piso", piso_actual, 0);
    chk("r31_solic", solicitudes, 0);
    m_reset();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    repeat (4) cyc('0, 1'b1, 1'b0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      rb = '0;
      if ($urandom_range(0, 7) == 0)
        rb[$urandom_range(0, N - 1)] = 1'b1;
      cyc(rb, ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
